// File: rtl/gate_checker.sv
// gate_checker: walks a 2-input gate under test through all four input
// vectors, waits a configurable settle time per vector, compares the
// response against a latched truth table, and reports per-vector mismatches.
module gate_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] truth_table,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last value of the settle counter before moving on to CHECK.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic [2:0] err_count_q, err_count_d;
  logic [3:0] err_mask_q, err_mask_d;

  // State and result registers; reset clears everything, including results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      tt_q        <= 4'd0;
      err_count_q <= 3'd0;
      err_mask_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tt_q        <= tt_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
    end
  end

  // Next-state logic: sequence vectors, count settle time, score responses.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tt_d        = tt_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;
    case (state_q)
      IDLE, DONE: begin
        // A new request restarts from vector 0 with a freshly latched table.
        if (start) begin
          tt_d        = truth_table;
          err_count_d = 3'd0;
          err_mask_d  = 4'd0;
          idx_d       = 2'd0;
          cnt_d       = 4'd0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        // At most four mismatches per run, so the 3-bit count never wraps.
        if (y != tt_q[idx_q]) begin
          err_mask_d[idx_q] = 1'b1;
          err_count_d       = err_count_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only; y never reaches them directly.
  always_comb begin
    a         = (state_q != IDLE) & idx_q[1];
    b         = (state_q != IDLE) & idx_q[0];
    busy      = (state_q == SETTLE) || (state_q == CHECK);
    done      = (state_q == DONE);
    pass      = (state_q == DONE) && (err_count_q == 3'd0);
    err_count = err_count_q;
    err_mask  = err_mask_q;
  end

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker with a behavioural gate (OR / AND / tied-1)
// closing the loop from a/b back to y.
module tb_gate_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] truth_table;
  logic       a, b, y;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] err_mask;

  int mode;   // 0: OR gate, 1: AND gate, 2: y tied high
  int total = 0;
  int bad   = 0;

  gate_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .truth_table(truth_table),
    .a(a),
    .b(b),
    .y(y),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  // Gate under test.
  always_comb begin
    case (mode)
      0:       y = a | b;
      1:       y = a & b;
      2:       y = 1'b1;
      default: y = 1'b0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run: start pulse, vector walk with timing checks, final results.
  // glitch=1 re-pulses start with a different table during vector 1 settle.
  task automatic do_run(input logic [3:0] tt, input int m, input bit glitch,
                        input logic [2:0] ec, input logic [3:0] em, input logic ps);
    truth_table = tt;
    mode        = m;
    start       = 1'b1;
    tick;                       // edge T sampled start; now in cycle T+1
    start       = 1'b0;
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_pass", 32'(pass), 32'd0);
    chk("clr_ecnt", 32'(err_count), 32'd0);
    chk("clr_emask", 32'(err_mask), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("ab_vec", 32'({a, b}), 32'(k));
      chk("busy_run", 32'(busy), 32'd1);
      if (glitch && k == 1) begin
        start       = 1'b1;
        truth_table = ~tt;
      end
      tick;
      start = 1'b0;
      tick;
      if (k == 3) chk("done_early", 32'(done), 32'd0);
      tick;
    end
    // cycle T+13
    chk("done_set", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("ab_done", 32'({a, b}), 32'd3);
    chk("pass", 32'(pass), 32'(ps));
    chk("err_count", 32'(err_count), 32'(ec));
    chk("err_mask", 32'(err_mask), 32'(em));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    truth_table = 4'b0000;
    mode        = 0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_ecnt", 32'(err_count), 32'd0);
    chk("rst_emask", 32'(err_mask), 32'd0);
    chk("rst_ab", 32'({a, b}), 32'd0);

    // Idle holds with no start.
    tick;
    chk("idle_busy", 32'(busy), 32'd0);

    // OR gate against OR table: clean pass.
    do_run(4'b1110, 0, 1'b0, 3'd0, 4'b0000, 1'b1);

    // AND gate against OR table, started from DONE: vectors 1 and 2 fail.
    do_run(4'b1110, 1, 1'b0, 3'd2, 4'b0110, 1'b0);
    // Results hold in DONE.
    tick; tick; tick;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_ecnt", 32'(err_count), 32'd2);
    chk("hold_emask", 32'(err_mask), 32'b0110);
    chk("hold_pass", 32'(pass), 32'd0);

    // y tied high against AND table: vectors 0..2 fail.
    do_run(4'b1000, 2, 1'b0, 3'd3, 4'b0111, 1'b0);

    // Rerun with a correct gate after a failing run.
    do_run(4'b1110, 0, 1'b0, 3'd0, 4'b0000, 1'b1);

    // Start re-pulsed mid-run with a different table: ignored.
    do_run(4'b1110, 0, 1'b1, 3'd0, 4'b0000, 1'b1);

    // Every vector wrong: count reaches 4 without wrapping.
    do_run(4'b0000, 2, 1'b0, 3'd4, 4'b1111, 1'b0);

    // Reset during CHECK of vector 2.
    truth_table = 4'b1110;
    mode        = 1;
    start       = 1'b1;
    tick;                       // T+1
    start = 1'b0;
    repeat (8) tick;            // T+9: CHECK of vector 2
    chk("mid_ab", 32'({a, b}), 32'd2);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_pass", 32'(pass), 32'd0);
    chk("mrst_ecnt", 32'(err_count), 32'd0);
    chk("mrst_emask", 32'(err_mask), 32'd0);
    chk("mrst_ab", 32'({a, b}), 32'd0);
    tick;
    chk("mrst_idle", 32'(busy), 32'd0);

    // Fresh run after reset starts at vector 0 and passes.
    do_run(4'b1110, 0, 1'b0, 3'd0, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
